// File: rtl/wb_req_master.sv
// wb_req_master: single-outstanding Wishbone pipelined-mode master.
// Turns one valid/ready request into one Wishbone transaction, with a
// per-attempt timeout and a one-cycle completion pulse carrying status
// (00 ok, 01 err, 10 timeout, 11 retry exhausted) and read data.
// Optional feature macro: WB_REQ_MASTER_RETRY_EN. When defined, rty
// terminations are re-issued after a one-cycle backoff up to MAX_RETRY
// times; when undefined, rty is treated exactly like err.
module wb_req_master #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // request side
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_sel_i,
  input  logic [31:0]           req_dat_i,
  // response side
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_status_o,
  output logic [31:0]           rsp_dat_o,
  // Wishbone master port
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  localparam int unsigned TO_W  = 16;
  localparam int unsigned STS_W = 2;

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [STS_W-1:0] STS_OK  = 2'b00;
  localparam logic [STS_W-1:0] STS_ERR = 2'b01;
  localparam logic [STS_W-1:0] STS_TMO = 2'b10;
`ifdef WB_REQ_MASTER_RETRY_EN
  localparam logic [STS_W-1:0] STS_EXH = 2'b11;
  localparam int unsigned      RTY_W   = 4;
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);
`endif

  // Reject parameter values the counters cannot represent.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_req_master: TIMEOUT must be in 2..65535");
  end
  if (MAX_RETRY > 15) begin : g_bad_max_retry
    $error("wb_req_master: MAX_RETRY must be in 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
`ifdef WB_REQ_MASTER_RETRY_EN
    S_BACKOFF = 3'd3,
`endif
    S_RESP    = 3'd4
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
`ifdef WB_REQ_MASTER_RETRY_EN
  logic [RTY_W-1:0]  rty_cnt;
  logic              do_retry;
`endif

  logic              attempt_end;
  logic [STS_W-1:0]  end_status;
  logic              capture_rd;

  // Decode how the current attempt ends this cycle (err > rty > ack > timeout).
  always_comb begin
    attempt_end = 1'b0;
    end_status  = STS_OK;
    capture_rd  = 1'b0;
`ifdef WB_REQ_MASTER_RETRY_EN
    do_retry    = 1'b0;
`endif
    if (state == S_ISSUE || state == S_WAIT) begin
      if (wb_err_i) begin
        attempt_end = 1'b1;
        end_status  = STS_ERR;
      end
`ifdef WB_REQ_MASTER_RETRY_EN
      else if (wb_rty_i) begin
        if (rty_cnt == RTY_LAST) begin
          attempt_end = 1'b1;
          end_status  = STS_EXH;
        end else begin
          do_retry = 1'b1;
        end
      end
`else
      else if (wb_rty_i) begin
        attempt_end = 1'b1;
        end_status  = STS_ERR;
      end
`endif
      else if (wb_ack_i) begin
        attempt_end = 1'b1;
        end_status  = STS_OK;
        capture_rd  = !wb_we_o;
      end
      else if (to_cnt == TO_LAST) begin
        attempt_end = 1'b1;
        end_status  = STS_TMO;
      end
    end
  end

  // Transaction FSM with registered request, bus and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= '0;
      rsp_dat_o    <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_dat_o     <= '0;
      to_cnt       <= '0;
`ifdef WB_REQ_MASTER_RETRY_EN
      rty_cnt      <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_ready_o && req_valid_i) begin
            wb_adr_o    <= req_adr_i;
            wb_we_o     <= req_we_i;
            wb_sel_o    <= req_sel_i;
            wb_dat_o    <= req_dat_i;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            req_ready_o <= 1'b0;
            to_cnt      <= '0;
`ifdef WB_REQ_MASTER_RETRY_EN
            rty_cnt     <= '0;
`endif
            state       <= S_ISSUE;
          end else begin
            req_ready_o <= 1'b1;
          end
        end

        S_ISSUE, S_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (attempt_end) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= end_status;
            if (capture_rd) begin
              rsp_dat_o <= wb_dat_i;
            end
            state <= S_RESP;
          end
`ifdef WB_REQ_MASTER_RETRY_EN
          else if (do_retry) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rty_cnt  <= rty_cnt + RTY_W'(1);
            state    <= S_BACKOFF;
          end
`endif
          else if (state == S_ISSUE && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= S_WAIT;
          end
        end

`ifdef WB_REQ_MASTER_RETRY_EN
        // One idle bus cycle, then re-issue the same latched request.
        S_BACKOFF: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          to_cnt   <= '0;
          state    <= S_ISSUE;
        end
`endif

        S_RESP: begin
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
